// File: rtl/intt_stage_scheduler.sv
// Stage sequencer for one inverse-NTT pass: walks log_m from LOG_M_START down to LOG_M_END and
// drives the shared read/write/twiddle controls of every intt_core in a modulus lane.
module intt_stage_scheduler #(
    parameter int unsigned LOG_CORE_COUNT = 4,
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned PIPE_LAT       = 8,
    parameter int unsigned LOG_M_START    = 12,
    parameter int unsigned LOG_M_END      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              use_direct_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        log_m_o,
    output logic [1:0]        mode_o,
    output logic [9:0]        upper_i_o,
    output logic [9:0]        lower_i_o,
    output logic [ADDR_W-1:0] read_address_o,
    output logic [ADDR_W-1:0] write_address_o,
    output logic              write_enable_o,
    output logic              read_select_o,
    output logic              write_select_o,
    output logic              input_select_o,
    output logic [3:0]        stage_idx_o,
    output logic              result_bank_o
);

    localparam int unsigned W      = 2 ** ADDR_W;
    localparam int unsigned DrainW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(W - 1);
    localparam logic [DrainW-1:0] DrainLast  = DrainW'(PIPE_LAT - 1);
    localparam logic [3:0]        LogMStart  = 4'(LOG_M_START);
    localparam logic [3:0]        LogMEnd    = 4'(LOG_M_END);
    localparam logic [3:0]        ModeTwoMax = 4'(LOG_CORE_COUNT + 1);
    localparam logic [3:0]        ModeOneAt  = 4'(LOG_CORE_COUNT + 2);

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StSwap, StDone} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   rd_cnt_q;
    logic [DrainW-1:0]   drain_cnt_q;
    logic [3:0]          log_m_q;
    logic [3:0]          stage_idx_q;
    logic                busy_q;
    logic                done_q;
    logic                input_select_q;
    logic                read_select_q;
    logic                result_bank_q;
    logic [PIPE_LAT-1:0] vld_q;
    logic [ADDR_W-1:0]   addr_pipe_q [PIPE_LAT];
    logic [1:0]          mode;
    logic                flush;

    assign flush = abort_i && (state_q != StIdle);

    always_comb begin
        if (log_m_q <= ModeTwoMax) begin
            mode = 2'd2;
        end else if (log_m_q == ModeOneAt) begin
            mode = 2'd1;
        end else begin
            mode = 2'd0;
        end
    end

    always_comb begin
        upper_i_o = '0;
        lower_i_o = '0;
        if (state_q == StRead && mode == 2'd1) begin
            upper_i_o = 10'(rd_cnt_q);
            lower_i_o = 10'(rd_cnt_q) + 10'(W);
        end
    end

    // Write-back delay line: each issued read reappears as a write PIPE_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                addr_pipe_q[i] <= '0;
            end
        end else begin
            vld_q[0]       <= (state_q == StRead) && !flush;
            addr_pipe_q[0] <= rd_cnt_q;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                vld_q[i]       <= vld_q[i-1] && !flush;
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            rd_cnt_q       <= '0;
            drain_cnt_q    <= '0;
            log_m_q        <= LogMStart;
            stage_idx_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            input_select_q <= 1'b0;
            read_select_q  <= 1'b0;
            result_bank_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q        <= StIdle;
                busy_q         <= 1'b0;
                input_select_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            state_q        <= StRead;
                            rd_cnt_q       <= '0;
                            log_m_q        <= LogMStart;
                            stage_idx_q    <= '0;
                            input_select_q <= use_direct_i;
                            busy_q         <= 1'b1;
                        end
                    end
                    StRead: begin
                        if (rd_cnt_q == LastAddr) begin
                            state_q     <= StDrain;
                            drain_cnt_q <= '0;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + 1'b1;
                        end
                    end
                    StDrain: begin
                        if (drain_cnt_q == DrainLast) begin
                            state_q <= StSwap;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 1'b1;
                        end
                    end
                    StSwap: begin
                        read_select_q  <= ~read_select_q;
                        input_select_q <= 1'b0;
                        stage_idx_q    <= stage_idx_q + 1'b1;
                        if (log_m_q == LogMEnd) begin
                            state_q       <= StDone;
                            result_bank_q <= ~read_select_q;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                        end else begin
                            log_m_q  <= log_m_q - 1'b1;
                            rd_cnt_q <= '0;
                            state_q  <= StRead;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign log_m_o         = log_m_q;
    assign mode_o          = mode;
    assign read_address_o  = rd_cnt_q;
    assign write_address_o = addr_pipe_q[PIPE_LAT-1];
    assign write_enable_o  = vld_q[PIPE_LAT-1];
    assign read_select_o   = read_select_q;
    assign write_select_o  = ~read_select_q;
    assign input_select_o  = input_select_q;
    assign stage_idx_o     = stage_idx_q;
    assign result_bank_o   = result_bank_q;

endmodule

// File: doc/intt_stage_scheduler.md
Name: intt_stage_scheduler

Overview:
- Sequences one full inverse NTT pass over the array of intt_core instances.
- Steps log_m through every Gentleman-Sande stage and drives the cores' shared control inputs: mode, twiddle indices, RAM addresses, ping-pong bank selects, write enables and direct-input select.
- One instance per modulus lane; its outputs fan out to all cores of that lane.
- Host side is a start/busy/done handshake.

Parameters:
- LOG_CORE_COUNT, 4, log2 of cores per lane; sets the mode thresholds.
- ADDR_W, 9, core RAM address width; one stage issues W = 2^ADDR_W reads per RAM.
- PIPE_LAT, 8, cycles from read-address issue to result write-back (input register + BRAM + butterfly).
- LOG_M_START, 12, log_m of the first stage.
- LOG_M_END, 1, log_m of the last stage; must be ≥1 and ≤ LOG_M_START.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins a transform; sampled only in IDLE.
- use_direct  in  1  sampled with start; 1 = the first stage takes direct_input instead of core RAM.
- abort  in  1  synchronous abort; returns to IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse at completion.
- log_m  out  4  current stage.
- mode  out  2  twiddle addressing mode.
- upper_i  out  10  mode-1 twiddle offset, upper butterfly.
- lower_i  out  10  mode-1 twiddle offset, lower butterfly.
- read_address  out  ADDR_W  drives both upper_read_address and lower_read_address.
- write_address  out  ADDR_W  drives both write addresses.
- write_enable  out  1  core RAM write strobe.
- read_select  out  1  bank being read.
- write_select  out  1  bank being written; always equals ~read_select.
- input_select  out  1  1 = butterflies consume direct input.
- stage_idx  out  4  number of stages completed in the current run.
- result_bank  out  1  bank holding the final result; valid while done is high and in IDLE.

Behaviour:
- Reset values:
  - log_m = LOG_M_START; mode = f(LOG_M_START).
  - read_address, write_address, upper_i, lower_i, stage_idx = 0.
  - write_enable, busy, done, input_select, read_select, result_bank = 0; write_select = 1.
- Mode function f, combinational from log_m:
  - 2 if log_m ≤ LOG_CORE_COUNT+1;
  - 1 if log_m == LOG_CORE_COUNT+2;
  - 0 otherwise.
- States: IDLE, READ, DRAIN, SWAP, DONE.
- IDLE:
  - start=1 → READ.
  - On entry to READ: rd_cnt=0, log_m=LOG_M_START, stage_idx=0, input_select=use_direct.
  - read_select is kept from the previous run, so the previous result bank is reused as the source.
- READ:
  - read_address = rd_cnt, incremented every cycle.
  - In mode 1: upper_i = rd_cnt zero-extended to 10 bits; lower_i = rd_cnt + 2^ADDR_W.
  - In modes 0 and 2: upper_i = lower_i = 0.
  - After W cycles (rd_cnt == W-1) → DRAIN.
- Write-back pipeline:
  - A valid bit and a copy of rd_cnt pass through a PIPE_LAT-deep shift register.
  - write_enable and write_address are the delayed values: write k is asserted exactly PIPE_LAT cycles after read k.
  - Exactly W writes per stage; never more, never fewer.
- DRAIN:
  - Lasts PIPE_LAT cycles; the last write occurs in the final DRAIN cycle.
  - read_address holds its last value.
  - Then → SWAP.
- SWAP (1 cycle):
  - Toggle read_select/write_select; clear input_select; stage_idx += 1.
  - If log_m == LOG_M_END → DONE, with result_bank = new read_select.
  - Otherwise log_m -= 1, rd_cnt = 0 → READ.
- Cycle counts:
  - Per stage: W + PIPE_LAT + 1 cycles.
  - Total: (LOG_M_START-LOG_M_END+1) stages.
- DONE: done=1 for one cycle, busy drops in the same cycle, → IDLE.
- Handshake edge cases:
  - start while not in IDLE is ignored.
  - start in the same cycle DONE exits is not accepted (accepted only when the state is IDLE).
- abort (any non-IDLE state) → IDLE next cycle:
  - The delay line is flushed: write_enable = 0 from the next cycle on.
  - No done pulse; read_select retains its value.
  - abort has priority over every transition; abort in IDLE has no effect.
- rst_n low at any time → all reset values immediately; in-flight writes are dropped.
- Wrap-around: rd_cnt and the write-address pipeline wrap at W; the final address of every stage is W-1.

Test Plan:
- ADDR_W=3, PIPE_LAT=4, LOG_M_START=5, LOG_M_END=1, start with use_direct=0 → 5 stages of 13 cycles each:
  - done pulses exactly 65 cycles after the first READ cycle;
  - 40 write_enable cycles in total;
  - result_bank=1; stage_idx=5.
- Same configuration, one stage checked → read_address sequence 0..7; write_address 0..7 delayed by exactly 4 cycles; write_select always == ~read_select.
- LOG_CORE_COUNT=4, LOG_M_START=7 → mode sequence over the stages is 0,1,2,2,2,2,2.
  - In the mode-1 stage (log_m=6), at rd_cnt=5: upper_i=5, lower_i=13.
- start with use_direct=1 → input_select=1 during stage 0 only; cleared in the first SWAP; 0 in every later stage.
- abort asserted in the 3rd DRAIN cycle of stage 2:
  - IDLE next cycle; write_enable low from then on; no done pulse.
  - A subsequent start completes normally.
- rst_n asserted mid-READ → all outputs at reset values immediately, without a clock edge. start pulses while busy are ignored and the cycle count is unchanged.
